// File: rtl/spi_slave_rx_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_rx_tx
// Purpose  : SPI mode-0 slave (MSB first) oversampled in the clk domain, with a
//            one-deep valid/ready TX buffer and a received-frame strobe.
//            Optional feature macro: SPI_SLAVE_OVERRUN_EN (held rx_valid,
//            rx_ack input, sticky overrun output).
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_rx_tx #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IDLE_BYTE   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             cs,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  logic             rx_ack,
    output logic             overrun,
`endif
    output logic             busy
);

    localparam int                 c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [WIDTH-1:0]   r_tx_sh;
    logic [WIDTH-2:0]   r_rx_sh;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_frame_done;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_rx_valid;
    logic [WIDTH-1:0]   r_buf;
    logic               r_buf_full;

    logic             w_sclk_s;
    logic             w_cs_s;
    logic             w_mosi_s;
    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic             w_cs_rise;
    logic             w_cs_fall;
    logic             w_load_idle;
    logic             w_reload;
    logic             w_load;
    logic             w_abort;
    logic             w_rise_cap;
    logic             w_done;
    logic             w_shift_tx;
    logic             w_wr;
    logic [WIDTH-1:0] w_load_byte;
    logic [WIDTH-1:0] w_rx_next;

    // Synchronisers; cs resets high so a master already selecting at reset
    // release still produces a clean falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // cs deselect outranks any sclk edge seen in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_load_idle  = 1'b0;
        w_reload     = 1'b0;
        w_abort      = 1'b0;
        w_rise_cap   = 1'b0;
        w_done       = 1'b0;
        w_shift_tx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = S_SHIFT;
                    w_load_idle  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    if (w_sclk_rise) begin
                        w_rise_cap = 1'b1;
                        w_done     = (r_bit_cnt == c_CNT_LAST);
                    end
                    if (w_sclk_fall) begin
                        if (r_bit_cnt != '0) begin
                            w_shift_tx = 1'b1;
                        end else if (r_frame_done) begin
                            w_reload = 1'b1;
                        end
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_load      = w_load_idle | w_reload;
    assign w_load_byte = r_buf_full ? r_buf : IDLE_BYTE;
    assign w_rx_next   = {r_rx_sh, w_mosi_s};
    assign w_wr        = tx_valid & ~r_buf_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_sh      <= '0;
            r_rx_sh      <= '0;
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_rx_data    <= '0;
        end else begin
            if (w_load) begin
                r_tx_sh <= w_load_byte;
            end else if (w_shift_tx) begin
                r_tx_sh <= {r_tx_sh[WIDTH-2:0], 1'b0};
            end else if (w_abort) begin
                r_tx_sh <= '0;
            end

            if (w_load_idle) begin
                r_bit_cnt    <= '0;
                r_rx_sh      <= '0;
                r_frame_done <= 1'b0;
            end else if (w_abort) begin
                r_bit_cnt    <= '0;
                r_frame_done <= 1'b0;
            end else if (w_reload) begin
                r_frame_done <= 1'b0;
            end else if (w_rise_cap) begin
                r_rx_sh <= w_rx_next[WIDTH-2:0];
                if (w_done) begin
                    r_bit_cnt    <= '0;
                    r_rx_data    <= w_rx_next;
                    r_frame_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
                end
            end
        end
    end

    // A write and an empty-buffer load never collide on r_buf_full: the load
    // only consumes a full buffer, the write only fills an empty one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_wr) begin
            r_buf      <= tx_data;
            r_buf_full <= 1'b1;
        end else if (w_load && r_buf_full) begin
            r_buf_full <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_done) begin
                r_rx_valid <= 1'b1;
            end else if (rx_ack) begin
                r_rx_valid <= 1'b0;
            end
            if (rx_ack) begin
                r_overrun <= 1'b0;
            end else if (w_done && r_rx_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign overrun = r_overrun;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_done;
        end
    end
`endif

    assign MISO     = r_tx_sh[WIDTH-1];
    assign tx_ready = ~r_buf_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_rx_tx
// Purpose  : Self-checking bench for spi_slave_rx_tx: SPI master model plus a
//            frame-level reference model of the TX buffer and RX stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx_tx;

    localparam int         HP     = 5;
    localparam logic [7:0] IDLE_B = 8'h00;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       sclk     = 1'b0;
    logic       cs       = 1'b1;
    logic       MOSI     = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       MISO;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       rx_ack   = 1'b0;
    logic       overrun;
    bit         auto_ack = 1'b1;
    bit         man_ack  = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit         m_full = 1'b0;
    logic [7:0] m_buf  = 8'h00;
    logic [7:0] m_tx   = 8'h00;
    logic [7:0] m_last_rx = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    spi_slave_rx_tx #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .IDLE_BYTE   (IDLE_B)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sclk     (sclk),
        .cs       (cs),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
`ifdef SPI_SLAVE_OVERRUN_EN
        .rx_ack   (rx_ack),
        .overrun  (overrun),
`endif
        .busy     (busy)
    );

    // Collect one entry per received frame.
    always @(negedge clk) begin
`ifdef SPI_SLAVE_OVERRUN_EN
        if (auto_ack && rx_valid && !rx_ack) got_q.push_back(rx_data);
        rx_ack = auto_ack ? rx_valid : man_ack;
`else
        if (rx_valid) got_q.push_back(rx_data);
`endif
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] take();
        logic [7:0] v;
        v = m_full ? m_buf : IDLE_B;
        m_full = 1'b0;
        return v;
    endfunction

    task automatic do_write(input logic [7:0] d);
        n_vec++;
        if (tx_ready !== (m_full ? 1'b0 : 1'b1)) begin
            n_err++;
            $display("FAIL tx_ready_before_write: got %b expected %b", tx_ready, !m_full);
        end
        tx_valid = 1'b1;
        tx_data  = d;
        clks(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        if (!m_full) begin
            m_buf  = d;
            m_full = 1'b1;
        end
        n_vec++;
        if (tx_ready !== 1'b0) begin
            n_err++;
            $display("FAIL tx_ready_after_write: got %b expected 0", tx_ready);
        end
    endtask

    task automatic cs_fall();
        cs   = 1'b0;
        m_tx = take();
        clks(HP);
    endtask

    task automatic cs_rise();
        cs = 1'b1;
        clks(HP);
    endtask

    // Mode-0 master: data set in the low phase, sampled on the sclk rise.
    task automatic shift_bits(input logic [7:0] mo, input int nbits, input int wr_at,
                              input logic [7:0] wd, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = mo[7-i];
            if (i == wr_at) begin
                do_write(wd);
                clks(HP - 1);
            end else begin
                clks(HP);
            end
            sclk     = 1'b1;
            mi[7-i]  = MISO;
            clks(HP);
            sclk     = 1'b0;
        end
    endtask

    task automatic full_frame(input logic [7:0] mo, input int wr_at, input logic [7:0] wd);
        logic [7:0] mi;
        shift_bits(mo, 8, wr_at, wd, mi);
        clks(HP);
        n_vec++;
        if (mi !== m_tx) begin
            n_err++;
            $display("FAIL miso_frame: got %h expected %h", mi, m_tx);
        end
        exp_q.push_back(mo);
        m_last_rx = mo;
        m_tx      = take();
    endtask

    task automatic partial_frame(input logic [7:0] mo, input int k);
        logic [7:0] mi;
        logic [7:0] mask;
        shift_bits(mo, k, -1, 8'h00, mi);
        mask = 8'hFF;
        mask = mask << (8 - k);
        n_vec++;
        if ((mi & mask) !== (m_tx & mask)) begin
            n_err++;
            $display("FAIL miso_partial: got %h expected %h", mi & mask, m_tx & mask);
        end
    endtask

    task automatic check_rx();
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rx_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rx_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        n_vec++;
        if (rx_data !== m_last_rx) begin
            n_err++;
            $display("FAIL rx_data_hold: got %h expected %h", rx_data, m_last_rx);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs();
        n_vec++;
        if (busy !== 1'b0 || MISO !== 1'b0) begin
            n_err++;
            $display("FAIL idle_outputs: busy=%b miso=%b expected 0 0", busy, MISO);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clks(3);
        n_vec++;
        if (MISO !== 1'b0)     begin n_err++; $display("FAIL reset_miso: got %b expected 0", MISO); end
        n_vec++;
        if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        n_vec++;
        if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_vec++;
        if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_vec++;
        if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef SPI_SLAVE_OVERRUN_EN
        n_vec++;
        if (overrun !== 1'b0)  begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
`endif
        reset = 1'b0;
        clks(HP);
    endtask

    task automatic test_basic();
        do_write(8'h3C);
        cs_fall();
        n_vec++;
        if (busy !== 1'b1 || tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_load: busy=%b tx_ready=%b expected 1 1", busy, tx_ready);
        end
        full_frame(8'hA5, -1, 8'h00);
        cs_rise();
        check_idle_outputs();
        check_rx();
    endtask

    task automatic test_partial();
        logic [7:0] w;
        w = 8'($urandom);
        cs_fall();
        partial_frame(8'hF0, 4);
        do_write(w);
        cs_rise();
        check_idle_outputs();
        check_rx();
        n_vec++;
        if (tx_ready !== 1'b0) begin
            n_err++;
            $display("FAIL partial_buffer_kept: got tx_ready %b expected 0", tx_ready);
        end
        cs_fall();
        full_frame(8'h81, -1, 8'h00);
        cs_rise();
        check_rx();
    endtask

    task automatic test_idle_byte();
        cs_fall();
        full_frame(8'hFF, -1, 8'h00);
        cs_rise();
        check_rx();
    endtask

    task automatic test_back_to_back();
        do_write(8'($urandom));
        cs_fall();
        full_frame(8'h12, 3, 8'($urandom));
        full_frame(8'h34, -1, 8'h00);
        cs_rise();
        check_rx();
    endtask

    task automatic test_random();
        for (int t = 0; t < 14; t++) begin
            int nf;
            if ($urandom_range(0, 1) == 1) do_write(8'($urandom));
            clks(2);
            cs_fall();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                int wa;
                wa = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 7));
                full_frame(8'($urandom), wa, 8'($urandom));
            end
            if (nf == 0 || $urandom_range(0, 2) == 0) begin
                partial_frame(8'($urandom), int'($urandom_range(1, 7)));
            end
            cs_rise();
            check_idle_outputs();
            check_rx();
            clks(int'($urandom_range(0, 6)));
        end
    endtask

`ifdef SPI_SLAVE_OVERRUN_EN
    task automatic test_overrun();
        logic [7:0] b2;
        b2       = 8'($urandom);
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        clks(2);
        cs_fall();
        full_frame(8'($urandom), -1, 8'h00);
        full_frame(b2, -1, 8'h00);
        cs_rise();
        n_vec++;
        if (overrun !== 1'b1 || rx_valid !== 1'b1 || rx_data !== b2) begin
            n_err++;
            $display("FAIL overrun_set: ovr=%b vld=%b data=%h expected 1 1 %h",
                     overrun, rx_valid, rx_data, b2);
        end
        man_ack = 1'b1;
        clks(3);
        man_ack = 1'b0;
        clks(2);
        n_vec++;
        if (overrun !== 1'b0 || rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_ack: ovr=%b vld=%b expected 0 0", overrun, rx_valid);
        end
        exp_q.delete();
        got_q.delete();
        auto_ack = 1'b1;
        clks(2);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_idle_byte();
        test_back_to_back();
        test_random();
`ifdef SPI_SLAVE_OVERRUN_EN
        test_overrun();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
